espif_regs: RTL and testbench

CPU-side register block that services the aq32 boot loader's accesses to the ESP command link, i.e. the responder end of the polled status/data protocol at I/O base 0x2000. It buffers bytes written by the CPU into a transmit FIFO, with start-of-frame marking, and presents them as a 9-bit stream to the link serializer. It buffers bytes arriving from the link into a receive FIFO for polled reads. It sits between the CPU I/O decoder and the ESP UART.

---
 rtl/espif_pkg.sv | 29 ++
 rtl/espif_fifo.sv | 58 +++++
 rtl/espif_regs.sv | 111 +++++++++++
 tb/tb_espif_regs.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/espif_pkg.sv
// Shared constants for the ESP command-link register block.
package espif_pkg;

  // Word offsets within the block (bus_addr)
  localparam logic ESPIF_STATUS = 1'b0;
  localparam logic ESPIF_DATA   = 1'b1;

  // STATUS register bit positions
  localparam int unsigned ST_RXNE   = 0;
  localparam int unsigned ST_TXFULL = 1;
  localparam int unsigned ST_RXOVF  = 2;
  localparam int unsigned ST_TXOVF  = 3;

  // Start-of-frame marker position in a TX stream word
  localparam int unsigned ESPIF_SOF_BIT = 8;

  // Assemble the STATUS read value; unused bits read as zero.
  function automatic logic [31:0] status_word(input logic rxne, input logic txfull,
                                              input logic rxovf, input logic txovf);
    logic [31:0] w;
    w            = '0;
    w[ST_RXNE]   = rxne;
    w[ST_TXFULL] = txfull;
    w[ST_RXOVF]  = rxovf;
    w[ST_TXOVF]  = txovf;
    return w;
  endfunction

endpackage

// File: rtl/espif_fifo.sv
// Register-based synchronous FIFO with combinational head. A pop in the same
// cycle as a push on a full FIFO frees the slot, so the push is accepted.
module espif_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned Depth = 1 << AW;

  logic [WIDTH-1:0] mem_q [Depth];
  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic             pop_ok, push_ok;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign head    = mem_q[rptr_q[AW-1:0]];

  // Pointer advance; extra MSB distinguishes full from empty
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push_ok) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
    if (pop_ok)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
  end

  // Pointer registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage; cleared on reset so the head reads zero when empty after reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wptr_q[AW-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/espif_regs.sv
// CPU-side register block for the ESP command link: STATUS/DATA decode,
// TX FIFO toward the link serializer, RX FIFO from the link, sticky overflows.
module espif_regs
  import espif_pkg::*;
#(
  parameter int unsigned TX_AW = 4,
  parameter int unsigned RX_AW = 5
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        bus_addr,
  input  logic        bus_wren,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [8:0]  tx_data,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data
);

  logic        tx_full, tx_empty, tx_push, tx_pop;
  logic        rx_full, rx_empty, rx_pop;
  logic [7:0]  rx_head;
  logic [8:0]  tx_wword;
  logic        tx_drop, rx_drop;
  logic        txovf_q, txovf_d, rxovf_q, rxovf_d;
  logic [31:0] rddata_q, rddata_d;
  logic        unused_wrdata;

  assign unused_wrdata = ^bus_wrdata[31:9];

  assign tx_wword = {bus_wrdata[ESPIF_SOF_BIT], bus_wrdata[7:0]};
  assign tx_push  = bus_wren && (bus_addr == ESPIF_DATA);
  assign tx_pop   = tx_valid && tx_ready;
  // A full FIFO is never empty, so a pop is possible exactly when tx_ready is high
  assign tx_drop  = tx_push && tx_full && !tx_ready;

  assign rx_pop   = bus_rden && (bus_addr == ESPIF_DATA) && !rx_empty;
  assign rx_drop  = rx_valid && rx_full && !rx_pop;

  assign tx_valid   = !tx_empty;
  assign bus_rddata = rddata_q;

  espif_fifo #(
    .WIDTH(9),
    .AW   (TX_AW)
  ) u_tx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (tx_push),
    .wdata  (tx_wword),
    .pop    (tx_pop),
    .full   (tx_full),
    .empty  (tx_empty),
    .head   (tx_data)
  );

  espif_fifo #(
    .WIDTH(8),
    .AW   (RX_AW)
  ) u_rx_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .push   (rx_valid),
    .wdata  (rx_data),
    .pop    (rx_pop),
    .full   (rx_full),
    .empty  (rx_empty),
    .head   (rx_head)
  );

  // Sticky flags: a new overflow wins over a same-cycle clear
  always_comb begin
    txovf_d = txovf_q;
    rxovf_d = rxovf_q;
    if (bus_wren && (bus_addr == ESPIF_STATUS)) begin
      if (bus_wrdata[ST_TXOVF]) txovf_d = 1'b0;
      if (bus_wrdata[ST_RXOVF]) rxovf_d = 1'b0;
    end
    if (tx_drop) txovf_d = 1'b1;
    if (rx_drop) rxovf_d = 1'b1;
  end

  // Read data: sampled from pre-update state, held until the next read
  always_comb begin
    rddata_d = rddata_q;
    if (bus_rden) begin
      if (bus_addr == ESPIF_STATUS) begin
        rddata_d = status_word(!rx_empty, tx_full, rxovf_q, txovf_q);
      end else begin
        rddata_d = rx_empty ? 32'h0 : {24'h0, rx_head};
      end
    end
  end

  // Flag and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      txovf_q  <= 1'b0;
      rxovf_q  <= 1'b0;
      rddata_q <= '0;
    end else begin
      txovf_q  <= txovf_d;
      rxovf_q  <= rxovf_d;
      rddata_q <= rddata_d;
    end
  end

endmodule

// File: tb/tb_espif_regs.sv
// Directed self-checking bench for espif_regs.
module tb_espif_regs;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        bus_addr = 1'b0;
  logic        bus_wren = 1'b0;
  logic [31:0] bus_wrdata = '0;
  logic        bus_rden = 1'b0;
  logic [31:0] bus_rddata;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [8:0]  tx_data;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = '0;

  int checks = 0;
  int errors = 0;

  logic [8:0] captured[$];

  espif_regs #(
    .TX_AW(4),
    .RX_AW(5)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus_addr  (bus_addr),
    .bus_wren  (bus_wren),
    .bus_wrdata(bus_wrdata),
    .bus_rden  (bus_rden),
    .bus_rddata(bus_rddata),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .tx_data   (tx_data),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data)
  );

  always #5 clk = ~clk;

  // Record every word the serializer accepts
  always @(posedge clk) begin
    if (reset_n && tx_valid && tx_ready) captured.push_back(tx_data);
  end

  // Inputs change on the falling edge; the DUT samples them on the next rising edge.
  task automatic bus_write(input logic addr, input logic [31:0] data);
    @(negedge clk);
    bus_addr   = addr;
    bus_wrdata = data;
    bus_wren   = 1'b1;
    @(negedge clk);
    bus_wren   = 1'b0;
  endtask

  task automatic bus_read(input logic addr, output logic [31:0] data);
    @(negedge clk);
    bus_addr = addr;
    bus_rden = 1'b1;
    @(negedge clk);
    bus_rden = 1'b0;
    data     = bus_rddata;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 9'h0 || bus_rddata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b data=%h rd=%h, want 0/000/0", tx_valid, tx_data,
               bus_rddata);
    end
    reset_n = 1'b1;
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL reset_status: got %h want 0", r); end
    checks++;
    if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_txvalid: got %b want 0", tx_valid); end
    bus_read(1'b1, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL empty_data_read: got %h want 0", r); end
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL status_after_empty_read: got %h want 0", r); end
  endtask

  task automatic test_boot_sequence();
    logic [8:0] exp[12];
    exp = '{9'h100, 9'h010, 9'h000, 9'h061, 9'h071, 9'h033, 9'h032, 9'h02e,
            9'h072, 9'h06f, 9'h06d, 9'h000};
    captured.delete();
    tx_ready = 1'b1;
    // Back-to-back writes: one word per cycle
    @(negedge clk);
    bus_addr = 1'b1;
    bus_wren = 1'b1;
    for (int i = 0; i < 12; i++) begin
      bus_wrdata = {23'h7abcde, exp[i]};
      @(negedge clk);
    end
    bus_wren = 1'b0;
    repeat (4) @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (captured.size() != 12) begin
      errors++;
      $display("FAIL boot_count: got %0d want 12", captured.size());
    end
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (i >= captured.size() || captured[i] !== exp[i]) begin
        errors++;
        $display("FAIL boot_word[%0d]: got %h want %h", i,
                 (i < captured.size()) ? captured[i] : 9'h1ff, exp[i]);
      end
    end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] r;
    captured.delete();
    tx_ready = 1'b0;
    bus_write(1'b1, 32'h0000_0180);
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 9'h180) begin
      errors++;
      $display("FAIL tx_first_visible: got valid=%b data=%h want 1/180", tx_valid, tx_data);
    end
    for (int i = 1; i < 16; i++) bus_write(1'b1, 32'h0000_0080 + i);
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL tx_full_status: got %h want 2", r); end
    bus_write(1'b1, 32'h0000_00ff);
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'ha) begin errors++; $display("FAIL tx_ovf_status: got %h want a", r); end
    // Read data holds with no further reads
    repeat (3) @(negedge clk);
    checks++;
    if (bus_rddata !== 32'ha) begin errors++; $display("FAIL rddata_hold: got %h want a", bus_rddata); end
    tx_ready = 1'b1;
    repeat (20) @(negedge clk);
    tx_ready = 1'b0;
    checks++;
    if (captured.size() != 16) begin
      errors++;
      $display("FAIL tx_drain_count: got %0d want 16", captured.size());
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (i >= captured.size() ||
          captured[i] !== ((i == 0) ? 9'h180 : (9'h080 + 9'(i)))) begin
        errors++;
        $display("FAIL tx_drain_word[%0d]: got %h", i, (i < captured.size()) ? captured[i] : 9'h1ff);
      end
    end
    bus_write(1'b0, 32'h8);
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL tx_ovf_clear: got %h want 0", r); end
  endtask

  task automatic test_rx_poll();
    logic [31:0] r;
    logic [7:0]  bytes[3];
    bytes = '{8'h00, 8'h34, 8'h12};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rx_valid = 1'b1;
      rx_data  = bytes[i];
    end
    @(negedge clk);
    rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_read(1'b0, r);
      checks++;
      if (r !== 32'h1) begin errors++; $display("FAIL rx_poll_status[%0d]: got %h want 1", i, r); end
      bus_read(1'b1, r);
      checks++;
      if (r !== {24'h0, bytes[i]}) begin
        errors++;
        $display("FAIL rx_poll_data[%0d]: got %h want %h", i, r, bytes[i]);
      end
    end
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rx_poll_final: got %h want 0", r); end
  endtask

  task automatic test_rx_overflow();
    logic [31:0] r;
    @(negedge clk);
    rx_valid = 1'b1;
    for (int i = 0; i < 33; i++) begin
      rx_data = 8'h40 + 8'(i);
      @(negedge clk);
    end
    rx_valid = 1'b0;
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h5) begin errors++; $display("FAIL rx_ovf_status: got %h want 5", r); end
    for (int i = 0; i < 32; i++) begin
      bus_read(1'b1, r);
      checks++;
      if (r !== 32'h40 + i) begin
        errors++;
        $display("FAIL rx_ovf_data[%0d]: got %h want %h", i, r, 32'h40 + i);
      end
    end
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h4) begin errors++; $display("FAIL rx_ovf_sticky: got %h want 4", r); end
    bus_write(1'b0, 32'h4);
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0) begin errors++; $display("FAIL rx_ovf_clear: got %h want 0", r); end
  endtask

  task automatic test_full_push_pop_and_reset();
    logic [31:0] r;
    tx_ready = 1'b0;
    for (int i = 0; i < 16; i++) bus_write(1'b1, 32'h0000_0010 + i);
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL full_before_pp: got %h want 2", r); end
    // Same-cycle push and pop on a full FIFO
    @(negedge clk);
    bus_addr   = 1'b1;
    bus_wrdata = 32'h0000_01ff;
    bus_wren   = 1'b1;
    tx_ready   = 1'b1;
    @(negedge clk);
    bus_wren   = 1'b0;
    tx_ready   = 1'b0;
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h2) begin errors++; $display("FAIL full_push_pop: got %h want 2", r); end
    checks++;
    if (tx_data !== 9'h011) begin errors++; $display("FAIL full_pp_head: got %h want 011", tx_data); end
    // Reset mid-transfer
    tx_ready = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (tx_valid !== 1'b0 || tx_data !== 9'h0 || bus_rddata !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset: got valid=%b data=%h rd=%h want 0/000/0", tx_valid, tx_data,
               bus_rddata);
    end
    tx_ready = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    bus_read(1'b0, r);
    checks++;
    if (r !== 32'h0 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: got status=%h valid=%b want 0/0", r, tx_valid);
    end
  endtask

  initial begin
    test_reset();
    test_boot_sequence();
    test_tx_overflow();
    test_rx_poll();
    test_rx_overflow();
    test_full_push_pop_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
